// File: rtl/imem_loader_if.sv
// Instruction-memory write port between the boot loader and the core's IMEM.
interface imem_loader_if #(
   parameter int ADDR_W = 8
) ();
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (output imem_we, output imem_addr, output imem_wdata);
   modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: receives a length-prefixed program image over UART 8N1,
// packs little-endian 32-bit words into instruction memory, then releases
// the core reset. Framing errors and oversize images park the block in ERR.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | half-bit wait, then confirm start bit (else false start)
// RX_DATA  | sample 8 data bits, one per bit period, LSB first
// RX_STOP  | sample stop bit; 1 -> byte_valid, 0 -> frame_err
// LD_HDR0  | waiting for word-count low byte
// LD_HDR1  | waiting for word-count high byte, range check
// LD_DATA  | assembling words and writing them to IMEM
// LD_DONE  | image loaded, core released, further input ignored
// LD_ERR   | load failed, core held in reset until rst_n
module imem_loader #(
   parameter int CLKS_PER_BIT = 16,
   parameter int ADDR_W       = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                uart_rx,
   imem_loader_if.master       imem,
   output logic                core_rst_n,
   output logic                busy,
   output logic                done,
   output logic                err
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   // Depth is compared in 17 bits so that a 16-bit count of 2^16 still fits.
   localparam logic [16:0]      DEPTH    = 17'(1) << ADDR_W;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {LD_HDR0, LD_HDR1, LD_DATA, LD_DONE, LD_ERR} ld_state_t;

   rx_state_t         rx_state, rx_nxt;
   ld_state_t         ld_state, ld_nxt;

   logic              rx_s1, rx_s2;
   logic [CNT_W-1:0]  bit_cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        rx_shreg;
   logic              byte_valid;
   logic              frame_err;

   logic [15:0]       n_words;
   logic [15:0]       word_cnt;
   logic [1:0]        byte_idx;
   logic [31:0]       word_buf;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              busy_nxt;

   logic              cnt_zero;
   logic              start_evt;
   logic              false_start;
   logic [15:0]       hdr_n;
   logic              last_word;

   assign cnt_zero    = (bit_cnt == '0);
   assign start_evt   = (rx_state == RX_IDLE) && !rx_s2;
   assign false_start = (rx_state == RX_START) && cnt_zero && rx_s2;
   assign hdr_n       = {rx_shreg, n_words[7:0]};
   assign last_word   = (byte_idx == 2'd3) && (word_cnt == n_words - 16'd1);

   // Two-flop synchronizer; idles high so reset does not look like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= uart_rx;
         rx_s2 <= rx_s1;
      end
   end

   // Receiver next-state decode.
   always_comb begin
      rx_nxt = rx_state;
      case (rx_state)
         RX_IDLE:  if (!rx_s2) rx_nxt = RX_START;
         RX_START: if (cnt_zero) rx_nxt = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (cnt_zero && (bit_idx == 3'd7)) rx_nxt = RX_STOP;
         RX_STOP:  if (cnt_zero) rx_nxt = RX_IDLE;
         default:  rx_nxt = RX_IDLE;
      endcase
   end

   // Receiver state, bit timer and shift register; byte_valid/frame_err are
   // registered so they appear the cycle after the stop-bit sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state   <= RX_IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         rx_shreg   <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_state   <= rx_nxt;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (rx_state)
            RX_IDLE: bit_cnt <= HALF_BIT;
            RX_START: begin
               if (cnt_zero) begin
                  bit_cnt <= FULL_BIT;
                  bit_idx <= '0;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_zero) begin
                  rx_shreg <= {rx_s2, rx_shreg[7:1]};
                  bit_idx  <= bit_idx + 1'b1;
                  bit_cnt  <= FULL_BIT;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_zero) begin
                  if (rx_s2) byte_valid <= 1'b1;
                  else       frame_err  <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            default: bit_cnt <= '0;
         endcase
      end
   end

   // Loader next-state and busy decode.
   always_comb begin
      ld_nxt   = ld_state;
      busy_nxt = busy;
      case (ld_state)
         LD_HDR0: begin
            if (frame_err)       ld_nxt = LD_ERR;
            else if (byte_valid) ld_nxt = LD_HDR1;
            if (start_evt)   busy_nxt = 1'b1;
            if (false_start) busy_nxt = 1'b0;
         end
         LD_HDR1: begin
            if (frame_err) begin
               ld_nxt = LD_ERR;
            end else if (byte_valid) begin
               if (hdr_n == 16'd0)              ld_nxt = LD_DONE;
               else if ({1'b0, hdr_n} > DEPTH) ld_nxt = LD_ERR;
               else                             ld_nxt = LD_DATA;
            end
         end
         LD_DATA: begin
            if (frame_err)                    ld_nxt = LD_ERR;
            else if (byte_valid && last_word) ld_nxt = LD_DONE;
         end
         LD_DONE: ld_nxt = LD_DONE;
         LD_ERR:  ld_nxt = LD_ERR;
         default: ld_nxt = LD_ERR;
      endcase
      if ((ld_nxt == LD_DONE) || (ld_nxt == LD_ERR)) busy_nxt = 1'b0;
   end

   // Loader state, header capture, word assembly and IMEM write strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_state <= LD_HDR0;
         busy     <= 1'b0;
         n_words  <= '0;
         word_cnt <= '0;
         byte_idx <= '0;
         word_buf <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         ld_state <= ld_nxt;
         busy     <= busy_nxt;
         we_q     <= 1'b0;
         case (ld_state)
            LD_HDR0: if (byte_valid) n_words[7:0] <= rx_shreg;
            LD_HDR1: begin
               if (byte_valid) begin
                  n_words[15:8] <= rx_shreg;
                  word_cnt      <= '0;
                  byte_idx      <= '0;
               end
            end
            LD_DATA: begin
               if (byte_valid) begin
                  word_buf <= {rx_shreg, word_buf[31:8]};
                  byte_idx <= byte_idx + 1'b1;
                  if (byte_idx == 2'd3) begin
                     we_q     <= 1'b1;
                     addr_q   <= word_cnt[ADDR_W-1:0];
                     wdata_q  <= {rx_shreg, word_buf[31:8]};
                     word_cnt <= word_cnt + 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign imem.imem_we    = we_q;
   assign imem.imem_addr  = addr_q;
   assign imem.imem_wdata = wdata_q;
   assign core_rst_n      = (ld_state == LD_DONE);
   assign done            = (ld_state == LD_DONE);
   assign err             = (ld_state == LD_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: UART byte driver, write scoreboard, scenario tasks.
module tb_imem_loader;
   localparam int CPB    = 16;
   localparam int ADDR_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic uart_rx = 1'b1;
   logic core_rst_n, busy, done, err;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   logic [39:0] exp_q[$];

   imem_loader_if #(.ADDR_W(ADDR_W)) imem ();

   imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .uart_rx    (uart_rx),
      .imem       (imem),
      .core_rst_n (core_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Scoreboard: every observed strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n && imem.imem_we) begin
         logic [39:0] e;
         wr_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write addr=%0h data=%08h", imem.imem_addr, imem.imem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({imem.imem_addr, imem.imem_wdata} !== e) begin
               errors++;
               $display("FAIL write_content got addr=%0h data=%08h want addr=%0h data=%08h",
                        imem.imem_addr, imem.imem_wdata, e[39:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      uart_rx = 1'b1;
      rst_n   = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      wr_cnt = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input logic [7:0] a);
      send_byte(w[7:0], 1'b1);
      send_byte(w[15:8], 1'b1);
      send_byte(w[23:16], 1'b1);
      exp_q.push_back({a, w});
      send_byte(w[31:24], 1'b1);
   endtask

   task automatic check_outputs_idle(input string tag);
      checks++;
      if ({imem.imem_we, imem.imem_addr, imem.imem_wdata, core_rst_n, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL %s we=%b addr=%0h wdata=%08h core_rst_n=%b busy=%b done=%b err=%b want all 0",
                  tag, imem.imem_we, imem.imem_addr, imem.imem_wdata, core_rst_n, busy, done, err);
      end
   endtask

   task automatic check_final(input string tag, input logic e_done, input logic e_err, input int e_wr);
      checks++;
      if ({core_rst_n, done, err, busy} !== {e_done, e_done, e_err, 1'b0} || wr_cnt != e_wr
          || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s core_rst_n=%b done=%b err=%b busy=%b writes=%0d pending=%0d want core_rst_n=%b done=%b err=%b busy=0 writes=%0d pending=0",
                  tag, core_rst_n, done, err, busy, wr_cnt, exp_q.size(), e_done, e_done, e_err, e_wr);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs_idle("reset_asserted");
      do_reset();
      check_outputs_idle("reset_released");
   endtask

   task automatic test_single_word();
      logic got, prev;
      do_reset();
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy got=%b want=1", busy);
      end
      send_byte(8'h13, 1'b1);
      send_byte(8'h05, 1'b1);
      send_byte(8'h50, 1'b1);
      exp_q.push_back({8'h00, 32'h00500513});
      got  = 1'b0;
      prev = 1'bx;
      fork
         send_byte(8'h00, 1'b1);
         begin
            for (int i = 0; i < 400 && !got; i++) begin
               @(negedge clk);
               if (imem.imem_we) got = 1'b1;
               else prev = core_rst_n;
            end
            checks++;
            if (!got) begin
               errors++;
               $display("FAIL single_strobe_timeout got=none want=strobe");
            end else begin
               checks++;
               if (prev !== 1'b0) begin
                  errors++;
                  $display("FAIL single_core_rst_before got=%b want=0", prev);
               end
               @(negedge clk);
               checks++;
               if (core_rst_n !== 1'b1 || imem.imem_we !== 1'b0) begin
                  errors++;
                  $display("FAIL single_after_strobe core_rst_n=%b we=%b want 1 and 0", core_rst_n, imem.imem_we);
               end
            end
         end
      join
      check_final("single_final", 1'b1, 1'b0, 1);
   endtask

   task automatic test_three_words();
      do_reset();
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b1);
      send_word(32'h00500513, 8'h00);
      send_word(32'h00A00593, 8'h01);
      checks++;
      if (done !== 1'b0 || core_rst_n !== 1'b0 || busy !== 1'b1 || wr_cnt != 2) begin
         errors++;
         $display("FAIL three_mid done=%b core_rst_n=%b busy=%b writes=%0d want 0 0 1 2",
                  done, core_rst_n, busy, wr_cnt);
      end
      send_word(32'h00B50633, 8'h02);
      check_final("three_final", 1'b1, 1'b0, 3);
      checks++;
      if (imem.imem_addr !== 8'h02 || imem.imem_wdata !== 32'h00B50633) begin
         errors++;
         $display("FAIL three_hold addr=%0h data=%08h want 2 00b50633", imem.imem_addr, imem.imem_wdata);
      end
      send_word(32'hFFFFFFFF, 8'h03);
      exp_q.delete();
      check_final("done_ignores_input", 1'b1, 1'b0, 3);
   endtask

   task automatic test_zero_words();
      do_reset();
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      check_final("zero_words", 1'b1, 1'b0, 0);
   endtask

   task automatic test_oversize();
      do_reset();
      send_byte(8'h01, 1'b1);
      send_byte(8'h01, 1'b1);
      check_final("oversize_hdr", 1'b0, 1'b1, 0);
      for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 1'b1);
      check_final("oversize_more_bytes", 1'b0, 1'b1, 0);
   endtask

   task automatic test_framing();
      do_reset();
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h13, 1'b1);
      send_byte(8'h05, 1'b1);
      send_byte(8'h50, 1'b0);
      check_final("framing_err", 1'b0, 1'b1, 0);
      send_byte(8'h00, 1'b1);
      check_final("framing_sticky", 1'b0, 1'b1, 0);
   endtask

   task automatic test_glitch();
      logic seen;
      do_reset();
      uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      uart_rx = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL glitch_busy_rise got=0 want=1");
      end
      repeat (30) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL glitch_settle busy=%b done=%b err=%b want 0 0 0", busy, done, err);
      end
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_word(32'h12345678, 8'h00);
      check_final("load_after_glitch", 1'b1, 1'b0, 1);
   endtask

   task automatic test_reset_mid_word();
      do_reset();
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_word(32'h00500513, 8'h00);
      send_byte(8'h93, 1'b1);
      send_byte(8'h05, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check_outputs_idle("mid_word_reset");
      rst_n = 1'b1;
      exp_q.delete();
      wr_cnt = 0;
      repeat (2) @(negedge clk);
      check_outputs_idle("mid_word_release");
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_word(32'hDEADBEEF, 8'h00);
      check_final("reload_after_reset", 1'b1, 1'b0, 1);
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_three_words();
      test_zero_words();
      test_oversize();
      test_framing();
      test_glitch();
      test_reset_mid_word();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader upstream of the single-cycle core. It receives a program image over a UART serial line, assembles little-endian 32-bit words, and writes them into the core's word-addressed instruction memory through its write port. The core's active-low reset is held asserted until the image is fully loaded, then released. Any error (framing error or oversize image) keeps the core in reset.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per UART bit; must be even and ≥ 4.
- ADDR_W, default 8: instruction-memory word-address width; depth is 2^ADDR_W words.

Ports:
- clk, input, 1: single clock. All state is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- uart_rx, input, 1: serial input, 8N1, LSB first, idle high. Asynchronous to clk.
- imem_we, output, 1: one-cycle write strobe to instruction memory.
- imem_addr, output, ADDR_W: word address. Increments by 1 per word, matching PC stepping by 1.
- imem_wdata, output, 32: assembled instruction word.
- core_rst_n, output, 1: active-low reset driven to the core. 0 while loading or on error.
- busy, output, 1: load in progress.
- done, output, 1: image loaded, core released. Sticky.
- err, output, 1: load failed. Sticky.

## Operation
**Image format**
- Byte 0 and byte 1 form N, a 16-bit word count, little-endian.
- 4·N data bytes follow. Each word is sent low byte first: byte k of a word lands in bits [8k+7:8k].

**UART receiver**
- uart_rx passes through a 2-flop synchronizer; both flops reset to 1.
- RX_IDLE → RX_START when the synchronized line is 0.
- In RX_START, count CLKS_PER_BIT/2 cycles, then resample:
  - 1 → false start, return to RX_IDLE with no byte.
  - 0 → RX_DATA.
- RX_DATA: sample every CLKS_PER_BIT cycles; 8 samples, LSB first.
- RX_STOP: sample once more after CLKS_PER_BIT cycles.
  - 1 → byte_valid pulses for 1 cycle.
  - 0 → framing error.
- Return to RX_IDLE in both cases.

**Loader FSM** (states: HDR0, HDR1, DATA, DONE, ERR; reset state HDR0)
- HDR0: on byte_valid, latch N[7:0] → HDR1.
- HDR1: on byte_valid, latch N[15:8], then:
  - N == 0 → DONE.
  - N > 2^ADDR_W → ERR.
  - otherwise → DATA, with word_cnt = 0 and byte_idx = 0.
- DATA: on each byte_valid, shift the byte into the word buffer and increment byte_idx (2-bit, wraps 3→0).
  - On the byte with byte_idx == 3: register imem_we = 1, imem_addr = word_cnt, imem_wdata = assembled word; then increment word_cnt.
  - On the write of word N−1 → DONE.
- DONE: core_rst_n = 1, done = 1, busy = 0. Further uart_rx activity is ignored; the receiver may run, but no writes occur.
- ERR: err = 1, core_rst_n = 0, busy = 0, no writes. Only rst_n exits this state.
- A framing error in HDR0, HDR1, or DATA → ERR.
- busy = 1 from the first RX_IDLE→RX_START transition in HDR0 until entering DONE or ERR. A false start in HDR0 clears busy again.
- imem_addr and imem_wdata hold their last written values between strobes.

**Reset**
- rst_n low at any time, including mid-byte or mid-word, asynchronously clears all state.
- Outputs after reset: imem_we = 0, imem_addr = 0, imem_wdata = 0, core_rst_n = 0, busy = 0, done = 0, err = 0.
- The next load restarts from HDR0.

## Timing
- One byte frame is 10·CLKS_PER_BIT cycles, plus 2 cycles of synchronizer latency.
- byte_valid is asserted the cycle after the stop-bit sample.
- imem_we is asserted the cycle after the byte_valid of the 4th byte of a word, for exactly 1 cycle.
- Entry to DONE or ERR is registered on the same edge as that event's last action. core_rst_n rises:
  - on the edge that registers the final imem_we (it is high the cycle after the strobe), or
  - on the edge after the HDR1 byte_valid when N == 0.
- err rises on the edge after the offending byte_valid or stop-bit sample.
- Minimum gap between imem_we pulses is 4 frames; no backpressure is needed.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and ADDR_W = 8.
- Single word: send 01 00 13 05 50 00 → exactly one imem_we with addr 0x00 and data 0x00500513; core_rst_n 0→1 the next cycle; done = 1; busy = 0.
- Three words: N = 03 00, then words 0x00500513, 0x00A00593, 0x00B50633 → three strobes at addr 0, 1, 2 with those values; done only after the third strobe.
- N = 0: send 00 00 → no imem_we; done = 1 and core_rst_n = 1 one cycle after the 2nd byte_valid.
- Oversize: send 01 01 (N = 257) → err = 1; core_rst_n stays 0; no imem_we even if more bytes are sent.
- Framing error: stop bit forced to 0 on the 3rd data byte → err = 1, no strobe, core_rst_n = 0.
- Glitch and reset:
  - uart_rx low for 4 cycles in idle → no byte accepted, busy returns to 0.
  - rst_n pulsed low after 2 data bytes of a word → all outputs at reset values.
  - A full 1-word load afterwards writes addr 0 correctly.
